// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard-detection inputs from the decoder/pipeline and register-enable/flush lines back.
// With HAZARD_PERF_CNT_EN defined the bundle also carries the StallCount/FlushCount performance counters.
`timescale 1ns/1ps
interface pipeline_hazard_ctrl_if;
    logic [4:0]  IFID_Rs1;
    logic [4:0]  IFID_Rs2;
    logic        IFID_UsesRs2;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_Rd;
    logic        EX_Redirect;
    logic        EXMEM_MemAccess;
    logic        DMemReady;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic        IDEXWrite;
    logic        IDEXFlush;
    logic        EXMEMWrite;
    logic        PCSel;
    logic        MemFault;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCount;
    logic [31:0] FlushCount;
`endif

    modport master (
        output IFID_Rs1, IFID_Rs2, IFID_UsesRs2, IDEX_MemRead, IDEX_Rd,
               EX_Redirect, EXMEM_MemAccess, DMemReady,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
               EXMEMWrite, PCSel, MemFault
`ifdef HAZARD_PERF_CNT_EN
        , input StallCount, FlushCount
`endif
    );

    modport slave (
        input  IFID_Rs1, IFID_Rs2, IFID_UsesRs2, IDEX_MemRead, IDEX_Rd,
               EX_Redirect, EXMEM_MemAccess, DMemReady,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
               EXMEMWrite, PCSel, MemFault
`ifdef HAZARD_PERF_CNT_EN
        , output StallCount, FlushCount
`endif
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage RV32 pipeline: load-use stalls, redirect flushes, data-memory waits.
// Optional macro HAZARD_PERF_CNT_EN adds StallCount/FlushCount performance counters.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LIMIT   = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    state_t     eff_state;
    logic       init_q, init_d;
    logic       ret_flush_q, ret_flush_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_fault_q, mem_fault_d;

    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, pc_sel;
    logic mem_wait, load_use;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= WAIT_LIMIT) ? v : v + 8'd1;
    endfunction

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs2
    );
        return mem_read && (rd != 5'd0) &&
               ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

    assign mem_wait = hz.EXMEM_MemAccess && !hz.DMemReady;
    assign load_use = load_use_hazard(hz.IDEX_MemRead, hz.IDEX_Rd,
                                      hz.IFID_Rs1, hz.IFID_Rs2, hz.IFID_UsesRs2);

    always_comb begin
        state_d     = state_q;
        init_d      = 1'b0;
        ret_flush_d = ret_flush_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        mem_fault_d = mem_fault_q;
        eff_state   = state_q;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_write  = 1'b0;
        idex_flush  = 1'b0;
        exmem_write = 1'b0;
        pc_sel      = 1'b0;

        if (init_q) begin
            // First cycle out of reset: hold everything and inject NOPs into IF/ID and ID/EX.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            if (state_q == S_MEM_WAIT) begin
                if (hz.DMemReady) begin
                    eff_state = ret_flush_q ? S_FLUSH : S_RUN;
                end else begin
                    wait_cnt_d = sat_inc(wait_cnt_q);
                    if (wait_cnt_d == WAIT_LIMIT) begin
                        mem_fault_d = 1'b1;
                    end
                end
            end

            // A released wait is evaluated with the rules of the state it interrupted.
            if (eff_state != S_MEM_WAIT) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_write  = 1'b1;
                exmem_write = 1'b1;
                state_d     = S_RUN;
                if (mem_wait) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_write = 1'b0;
                    state_d     = S_MEM_WAIT;
                    ret_flush_d = (eff_state == S_FLUSH);
                    wait_cnt_d  = 8'd1;
                    if (WAIT_LIMIT == 8'd1) begin
                        mem_fault_d = 1'b1;
                    end
                end else if (hz.EX_Redirect) begin
                    pc_sel     = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end
                end else if (eff_state == S_FLUSH) begin
                    ifid_flush  = 1'b1;
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    state_d     = (flush_cnt_d == 3'd0) ? S_RUN : S_FLUSH;
                end else if (load_use) begin
                    // The bubble clears IDEX_MemRead next cycle, so this stalls exactly once.
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_RUN;
            init_q      <= 1'b1;
            ret_flush_q <= 1'b0;
            flush_cnt_q <= 3'd0;
            wait_cnt_q  <= 8'd0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            ret_flush_q <= ret_flush_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    assign hz.PCWrite    = pc_write;
    assign hz.IFIDWrite  = ifid_write;
    assign hz.IFIDFlush  = ifid_flush;
    assign hz.IDEXWrite  = idex_write;
    assign hz.IDEXFlush  = idex_flush;
    assign hz.EXMEMWrite = exmem_write;
    assign hz.PCSel      = pc_sel;
    assign hz.MemFault   = mem_fault_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_evt_q, flush_evt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(!pc_write);
        flush_evt_d = flush_evt_q + 32'(ifid_flush);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_evt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_evt_q <= flush_evt_d;
        end
    end

    assign hz.StallCount = stall_cnt_q;
    assign hz.FlushCount = flush_evt_q;
`endif
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequencing controller for the 5-stage RV32 reduced-ISA pipeline; sits beside the main decoder and drives the pipeline-register write-enable and flush lines.
Handles load-use stalls, control-transfer flushes (beq taken, jal, jalr) and data-memory wait states.
It also has a memory-wait watchdog.
It is the single authority over PC and pipeline-register enables.

Parameters:
FLUSH_CYCLES, 1, cycles IF/ID is squashed after a redirect (1..7); covers instruction-memory latency
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before MemFault (8-bit counter, 1..255)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
IFID_Rs1  in  5  rs1 of instruction in ID
IFID_Rs2  in  5  rs2 of instruction in ID
IFID_UsesRs2  in  1  ID instruction reads rs2 (R-type, store, branch)
IDEX_MemRead  in  1  instruction in EX is a load
IDEX_Rd  in  5  destination of instruction in EX
EX_Redirect  in  1  EX resolves a taken branch, jal or jalr this cycle
EXMEM_MemAccess  in  1  instruction in MEM is a load or store
DMemReady  in  1  data memory completes access this cycle
PCWrite  out  1  PC register enable
IFIDWrite  out  1  IF/ID register enable
IFIDFlush  out  1  IF/ID loads a NOP
IDEXWrite  out  1  ID/EX register enable
IDEXFlush  out  1  ID/EX loads a bubble (all control bits 0)
EXMEMWrite  out  1  EX/MEM and MEM/WB enables
PCSel  out  1  PC takes redirect target
MemFault  out  1  sticky: memory wait exceeded MEM_TIMEOUT

Behaviour:
- One clock, clk. reset is asynchronous and active-high.
- Outputs while reset is asserted and on the first cycle after: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMWrite=0, IFIDFlush=1, IDEXFlush=1, PCSel=0, MemFault=0. State is RUN. Counters are 0.
- States:
  - RUN: normal flow.
  - MEM_WAIT: whole pipeline frozen.
  - FLUSH: squash IF/ID for the remaining flush cycles.
- Outputs are combinational from the state and the current inputs. State and counters are registered.
- Default outputs in RUN: all Write signals = 1, all Flush signals = 0, PCSel = 0.
- Priority in RUN, highest first:
  1. Memory wait: condition is EXMEM_MemAccess=1 and DMemReady=0.
     - All Write signals = 0; flushes and PCSel = 0.
     - Next state MEM_WAIT; the wait counter loads 1.
  2. Redirect: condition is EX_Redirect=1.
     - PCSel=1, PCWrite=1, IFIDFlush=1, IDEXFlush=1.
     - If FLUSH_CYCLES>1, next state FLUSH with the flush counter = FLUSH_CYCLES-1; otherwise stay in RUN.
     - A redirect overrides a coincident load-use hazard, because the ID instruction is discarded.
  3. Load-use: condition is IDEX_MemRead=1, IDEX_Rd!=0, and either (IDEX_Rd==IFID_Rs1) or (IFID_UsesRs2=1 and IDEX_Rd==IFID_Rs2).
     - PCWrite=0, IFIDWrite=0, IDEXFlush=1.
     - Exactly one bubble, because the bubble clears IDEX_MemRead on the next cycle. No state change.
- MEM_WAIT:
  - All Write signals = 0.
  - The wait counter increments each cycle, saturating at MEM_TIMEOUT.
  - When DMemReady=1, the frozen cycle is released: outputs are evaluated exactly as in RUN in that same cycle (a redirect or load-use present is honoured), and the next state follows those RUN rules.
  - When the counter reaches MEM_TIMEOUT with DMemReady still 0: MemFault is set (sticky until reset) and the pipeline stays frozen.
  - EX_Redirect is ignored while frozen; EX holds, so it is seen again at release.
- FLUSH:
  - PCWrite=1, IFIDFlush=1, IDEXFlush=0. The counter decrements; at 0, return to RUN.
  - A memory wait during FLUSH freezes the pipeline (MEM_WAIT). The flush count is preserved and resumes after release, i.e. the state returns to FLUSH.
  - A new EX_Redirect during FLUSH restarts the redirect sequence (PCSel=1, counter reloaded).
- Register x0: IDEX_Rd==0 never causes a stall.
- Reset asserted mid-MEM_WAIT or mid-FLUSH aborts immediately to the reset outputs. MemFault clears.

Optional Feature:
HAZARD_PERF_CNT_EN: adds output ports StallCount (32) and FlushCount (32).
- StallCount increments on every cycle with PCWrite=0 after reset.
- FlushCount increments on every cycle with IFIDFlush=1 and reset deasserted.
- Both wrap at 2^32 and clear on reset.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. Load-use: lw x5 in EX (IDEX_MemRead=1, IDEX_Rd=5), ID has IFID_Rs1=5 -> one cycle of PCWrite=0, IFIDWrite=0, IDEXFlush=1; the next cycle returns to all Write=1.
2. x0 and rs2 cases: IDEX_Rd=0 with IFID_Rs1=0 -> no stall. IDEX_Rd=7, IFID_Rs2=7, IFID_UsesRs2=0 -> no stall; with IFID_UsesRs2=1 -> one-cycle stall.
3. Redirect with FLUSH_CYCLES=3: EX_Redirect pulse -> PCSel=1 and IFIDFlush=1 for 3 consecutive cycles (PCSel only in the first), IDEXFlush=1 in the first only; coincident load-use is ignored.
4. Memory wait: EXMEM_MemAccess=1, DMemReady=0 for 4 cycles, then 1 -> all Write=0 for 4 cycles, released in the 5th cycle; MemFault stays 0.
5. Timeout with MEM_TIMEOUT=8: DMemReady held 0 -> MemFault=1 after the 8th wait cycle, remains 1 after DMemReady rises; reset clears it.
6. Reset mid-FLUSH (FLUSH_CYCLES=4, reset after the 2nd flush cycle) -> reset outputs immediately, then RUN defaults. With HAZARD_PERF_CNT_EN, StallCount and FlushCount read 0 after reset.
